// File: rtl/sobel_convolucao.sv
// Sobel gradient magnitude of one 3x3 window as a multi-cycle Nios II custom instruction.
// CARREGA latches p0..p7. CALCULA latches p8, then accumulates Gx/Gy one tap per cycle.
module sobel_convolucao #(
    parameter int LARGURA_ACC = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {OCIOSO, CARREGA_FIM, ACUMULA, MAGNITUDE, FIM} estado_t;

    estado_t                        estado;
    logic [3:0]                     k;
    logic [8:0][7:0]                jan;
    logic signed [LARGURA_ACC-1:0]  gx;
    logic signed [LARGURA_ACC-1:0]  gy;
    logic [7:0]                     pix;
    logic [10:0]                    soma;

    function automatic logic signed [2:0] coef_gx(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd6: return -3'sd1;
            4'd2, 4'd8: return 3'sd1;
            4'd3:       return -3'sd2;
            4'd5:       return 3'sd2;
            default:    return 3'sd0;
        endcase
    endfunction

    function automatic logic signed [2:0] coef_gy(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd2: return -3'sd1;
            4'd1:       return -3'sd2;
            4'd6, 4'd8: return 3'sd1;
            4'd7:       return 3'sd2;
            default:    return 3'sd0;
        endcase
    endfunction

    // Coefficient magnitudes are only 0, 1 or 2, so the product is a shift and the sign picks add/subtract.
    function automatic logic signed [LARGURA_ACC-1:0] produto(input logic [7:0] p,
                                                             input logic signed [2:0] c);
        logic signed [LARGURA_ACC-1:0] mag;
        mag = '0;
        if (c == 3'sd2 || c == -3'sd2)
            mag = signed'({{(LARGURA_ACC-9){1'b0}}, p, 1'b0});
        else if (c != 3'sd0)
            mag = signed'({{(LARGURA_ACC-8){1'b0}}, p});
        return (c < 3'sd0) ? -mag : mag;
    endfunction

    function automatic logic [10:0] modulo(input logic signed [LARGURA_ACC-1:0] v);
        logic signed [LARGURA_ACC-1:0] a;
        a = (v < 0) ? -v : v;
        return a[10:0];
    endfunction

    function automatic logic [7:0] satura(input logic [10:0] s);
        return (s > 11'd255) ? 8'hFF : s[7:0];
    endfunction

    assign pix  = jan[k];
    assign soma = modulo(gx) + modulo(gy);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            k      <= '0;
            jan    <= '0;
            gx     <= '0;
            gy     <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        case (n)
                            2'd0: begin
                                jan[3:0] <= dataa;
                                jan[7:4] <= datab;
                                result   <= '0;
                                done     <= 1'b1;
                                estado   <= CARREGA_FIM;
                            end
                            2'd1: begin
                                jan[8] <= dataa[7:0];
                                gx     <= '0;
                                gy     <= '0;
                                k      <= '0;
                                estado <= ACUMULA;
                            end
                            default: begin
                                result <= '0;
                                done   <= 1'b1;
                                estado <= CARREGA_FIM;
                            end
                        endcase
                    end
                end
                CARREGA_FIM: estado <= OCIOSO;
                ACUMULA: begin
                    gx <= gx + produto(pix, coef_gx(k));
                    gy <= gy + produto(pix, coef_gy(k));
                    if (k == 4'd8) begin
                        k      <= '0;
                        estado <= MAGNITUDE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                // result and done are written on the same edge so done always marks a valid result
                MAGNITUDE: begin
                    result <= {13'b0, soma, satura(soma)};
                    done   <= 1'b1;
                    estado <= FIM;
                end
                FIM:     estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_convolucao.sv
// Directed bench for sobel_convolucao: hand-computed windows, latency, stall and reset cases.
module tb_sobel_convolucao;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;

    sobel_convolucao #(.LARGURA_ACC(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .n       (n),
        .dataa   (dataa),
        .datab   (datab),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one instruction and watches 30 cycles; cycle 1 is the one right after the start edge.
    task automatic op(input logic [1:0] nn, input logic [31:0] a, input logic [31:0] b,
                      input int stall_at, input int stall_len, input bit poke,
                      output int lat, output logic [31:0] res, output int ndone);
        @(negedge clk);
        start = 1'b1; n = nn; dataa = a; datab = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; res = 32'hx; ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = result;
                end
            end
            clk_en = !(stall_at > 0 && c >= stall_at && c < stall_at + stall_len);
            if (poke && c == 3) begin
                start = 1'b1; n = 2'd0; dataa = 32'hFFFFFFFF; datab = 32'hFFFFFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        start  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] nn, input logic [31:0] a,
                       input logic [31:0] b, input int stall_at, input bit poke,
                       input int exp_lat, input logic [31:0] exp_res);
        int lat, nd;
        logic [31:0] res;
        op(nn, a, b, stall_at, 4, poke, lat, res, nd);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_ndone"}, nd, 1);
    endtask

    initial begin
        int nd;
        reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = '0; datab = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", result, 0);
        @(negedge clk) reset_n = 1'b1;
        #1;
        chk("post_rst_done", {31'b0, done}, 0);

        run("calc_zero",  2'd1, 32'h00000000, 32'hDEADBEEF, 0, 1'b0, 11, 32'h0);
        run("load_vert",  2'd0, 32'h00FF8000, 32'h8000FF80, 0, 1'b0, 1,  32'h0);
        run("calc_vert",  2'd1, 32'h000000FF, 32'hDEADBEEF, 0, 1'b0, 11, 32'h0003FCFF);
        run("reserved",   2'd2, 32'h11111111, 32'h22222222, 0, 1'b0, 1,  32'h0);
        run("calc_vert2", 2'd1, 32'h000000FF, 32'h0,        0, 1'b0, 11, 32'h0003FCFF);
        run("load_ramp",  2'd0, 32'h03020100, 32'h07060504, 0, 1'b0, 1,  32'h0);
        run("calc_ramp",  2'd1, 32'hABCDEF08, 32'hDEADBEEF, 0, 1'b0, 11, 32'h00002020);
        run("load_flat",  2'd0, 32'h64646464, 32'h64646464, 0, 1'b0, 1,  32'h0);
        run("calc_flat",  2'd1, 32'h00000064, 32'h0,        0, 1'b0, 11, 32'h0);
        run("load_ramp2", 2'd0, 32'h03020100, 32'h07060504, 0, 1'b0, 1,  32'h0);
        run("calc_stall", 2'd1, 32'h00000008, 32'h0,        4, 1'b1, 15, 32'h00002020);

        // Ramp window is still loaded and result holds 0x2020; reset lands in cycle 5 of a CALCULA.
        @(negedge clk);
        start = 1'b1; n = 2'd1; dataa = 32'h8; datab = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("midrst_nodone", nd, 0);
        chk("midrst_result_hold", result, 0);

        run("calc_cleared", 2'd1, 32'h00000000, 32'h0,        0, 1'b0, 11, 32'h0);
        run("load_ramp3",   2'd0, 32'h03020100, 32'h07060504, 0, 1'b0, 1,  32'h0);
        run("calc_ramp3",   2'd1, 32'h00000008, 32'h0,        0, 1'b0, 11, 32'h00002020);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
